// File: rtl/led_fade_sequencer.sv
// RGB status-LED keyframe sequencer: ramps three PWM duties 1 % per step
// between a fixed table of keyframes, holds at each, and wraps around.
module led_fade_sequencer #(
    parameter int                  STEP_CYCLES = 20000,
    parameter int                  HOLD_CYCLES = 2000000,
    parameter int                  N_KEYS      = 4,
    parameter logic [7*N_KEYS-1:0] KEYS_R      = '0,
    parameter logic [7*N_KEYS-1:0] KEYS_G      = '0,
    parameter logic [7*N_KEYS-1:0] KEYS_B      = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    output logic [6:0]                duty_r,
    output logic [6:0]                duty_g,
    output logic [6:0]                duty_b,
    output logic                      pwm_r,
    output logic                      pwm_g,
    output logic                      pwm_b,
    output logic [$clog2(N_KEYS)-1:0] key_idx,
    output logic                      key_done,
    output logic                      busy
);

    localparam int KW = $clog2(N_KEYS);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(N_KEYS - 1);
    localparam logic [6:0]    PWM_LAST  = 7'd99;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    function automatic logic [6:0] clamp_duty(input logic [6:0] v);
        return (v > 7'd100) ? 7'd100 : v;
    endfunction

    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        if (cur < tgt)      return cur + 7'd1;
        else if (cur > tgt) return cur - 7'd1;
        else                return cur;
    endfunction

    logic [6:0] key_r [N_KEYS];
    logic [6:0] key_g [N_KEYS];
    logic [6:0] key_b [N_KEYS];

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_keys
            assign key_r[gi] = clamp_duty(KEYS_R[7*gi +: 7]);
            assign key_g[gi] = clamp_duty(KEYS_G[7*gi +: 7]);
            assign key_b[gi] = clamp_duty(KEYS_B[7*gi +: 7]);
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [6:0]    duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic [KW-1:0] key_idx_q, key_idx_d, tgt_q, tgt_d;
    logic [SW-1:0] step_q, step_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [6:0]    pwm_cnt_q, pwm_cnt_d;
    logic          pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
    logic [6:0]    tgt_r, tgt_g, tgt_b;

    assign tgt_r = key_r[tgt_q];
    assign tgt_g = key_g[tgt_q];
    assign tgt_b = key_b[tgt_q];

    always_comb begin
        state_d   = state_q;
        duty_r_d  = duty_r_q;
        duty_g_d  = duty_g_q;
        duty_b_d  = duty_b_q;
        key_idx_d = key_idx_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        hold_d    = hold_q;
        key_done  = 1'b0;
        if (stop) begin
            state_d   = S_IDLE;
            duty_r_d  = '0;
            duty_g_d  = '0;
            duty_b_d  = '0;
            key_idx_d = '0;
            tgt_d     = '0;
            step_d    = '0;
            hold_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_RAMP;
                        duty_r_d  = key_r[0];
                        duty_g_d  = key_g[0];
                        duty_b_d  = key_b[0];
                        key_idx_d = '0;
                        tgt_d     = KW'(1);
                        step_d    = '0;
                        hold_d    = '0;
                    end
                end
                S_RAMP: begin
                    if (!pause) begin
                        if (step_q == STEP_LAST) begin
                            step_d   = '0;
                            duty_r_d = step_toward(duty_r_q, tgt_r);
                            duty_g_d = step_toward(duty_g_q, tgt_g);
                            duty_b_d = step_toward(duty_b_q, tgt_b);
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                        // Compare post-step duties so the final step and HOLD entry share an edge.
                        if (duty_r_d == tgt_r && duty_g_d == tgt_g && duty_b_d == tgt_b) begin
                            state_d   = S_HOLD;
                            key_idx_d = tgt_q;
                            hold_d    = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        if (hold_q == HOLD_LAST) begin
                            key_done = 1'b1;
                            tgt_d    = (key_idx_q == KEY_LAST) ? '0 : key_idx_q + 1'b1;
                            step_d   = '0;
                            hold_d   = '0;
                            state_d  = S_RAMP;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 7'd1;
        pwm_r_d   = (pwm_cnt_q < duty_r_q);
        pwm_g_d   = (pwm_cnt_q < duty_g_q);
        pwm_b_d   = (pwm_cnt_q < duty_b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            duty_r_q  <= '0;
            duty_g_q  <= '0;
            duty_b_q  <= '0;
            key_idx_q <= '0;
            tgt_q     <= '0;
            step_q    <= '0;
            hold_q    <= '0;
            pwm_cnt_q <= '0;
            pwm_r_q   <= 1'b0;
            pwm_g_q   <= 1'b0;
            pwm_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_r_q  <= duty_r_d;
            duty_g_q  <= duty_g_d;
            duty_b_q  <= duty_b_d;
            key_idx_q <= key_idx_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            hold_q    <= hold_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_r_q   <= pwm_r_d;
            pwm_g_q   <= pwm_g_d;
            pwm_b_q   <= pwm_b_d;
        end
    end

    assign duty_r  = duty_r_q;
    assign duty_g  = duty_g_q;
    assign duty_b  = duty_b_q;
    assign pwm_r   = pwm_r_q;
    assign pwm_g   = pwm_g_q;
    assign pwm_b   = pwm_b_q;
    assign key_idx = key_idx_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer: directed scenarios plus randomized start/stop/pause,
// every cycle compared against a time-based keyframe model.
module tb_led_fade_sequencer;

    localparam int STEP = 4;
    localparam int HOLD = 8;
    localparam int NK   = 3;
    localparam logic [20:0] KR = {7'd0,   7'd100, 7'd0};
    localparam logic [20:0] KG = {7'd50,  7'd0,   7'd0};
    localparam logic [20:0] KB = {7'd100, 7'd100, 7'd100};

    logic       clk = 1'b0;
    logic       rst_n, start, stop, pause;
    logic [6:0] duty_r, duty_g, duty_b;
    logic       pwm_r, pwm_g, pwm_b;
    logic [1:0] key_idx;
    logic       key_done, busy;

    led_fade_sequencer #(
        .STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD), .N_KEYS(NK),
        .KEYS_R(KR), .KEYS_G(KG), .KEYS_B(KB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .key_idx(key_idx), .key_done(key_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase, keyframes being ramped between, and active cycles spent in the phase.
    bit m_busy, m_hold;
    int m_from, m_to, m_el, m_key, m_cnt;
    bit e_pwm [3];

    int obs_duty_r, obs_key_idx, obs_key_done, obs_busy, obs_pwm_r, obs_pwm_b;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kval(input int ch, input int k);
        case (ch)
            0:       return (k == 1) ? 100 : 0;
            1:       return (k == 2) ? 50 : 0;
            default: return 100;
        endcase
    endfunction

    function automatic int ramp_len(input int f, input int t);
        int d = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int x = kval(ch, t) - kval(ch, f);
            if (x < 0) x = -x;
            if (x > d) d = x;
        end
        return (d == 0) ? 1 : d * STEP;
    endfunction

    function automatic int exp_duty(input int ch);
        int a, b, n, d;
        if (!m_busy) return 0;
        if (m_hold) return kval(ch, m_key);
        a = kval(ch, m_from);
        b = kval(ch, m_to);
        d = (b > a) ? b - a : a - b;
        n = m_el / STEP;
        if (n > d) n = d;
        return (b >= a) ? a + n : a - n;
    endfunction

    task automatic model_step(input bit s, input bit p, input bit ps);
        for (int ch = 0; ch < 3; ch++) e_pwm[ch] = (m_cnt < exp_duty(ch));
        m_cnt = (m_cnt + 1) % 100;
        if (p) begin
            m_busy = 0;
            m_key  = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_hold = 0; m_from = 0; m_to = 1; m_el = 0; m_key = 0;
            end
        end else if (!ps) begin
            m_el++;
            if (!m_hold) begin
                if (m_el >= ramp_len(m_from, m_to)) begin
                    m_hold = 1; m_key = m_to; m_el = 0;
                end
            end else if (m_el == HOLD) begin
                m_hold = 0; m_from = m_key; m_to = (m_key + 1) % NK; m_el = 0;
            end
        end
    endtask

    task automatic cycle(input bit s, input bit p, input bit ps);
        @(negedge clk);
        start = s; stop = p; pause = ps;
        #1;
        obs_duty_r   = int'(duty_r);
        obs_key_idx  = int'(key_idx);
        obs_key_done = int'(key_done);
        obs_busy     = int'(busy);
        obs_pwm_r    = int'(pwm_r);
        obs_pwm_b    = int'(pwm_b);
        check_eq("duty_r", int'(duty_r), exp_duty(0));
        check_eq("duty_g", int'(duty_g), exp_duty(1));
        check_eq("duty_b", int'(duty_b), exp_duty(2));
        check_eq("busy", int'(busy), int'(m_busy));
        check_eq("key_idx", int'(key_idx), m_key);
        check_eq("key_done", int'(key_done),
                 int'(m_busy && m_hold && m_el == HOLD - 1 && !ps && !p));
        check_eq("pwm_r", int'(pwm_r), int'(e_pwm[0]));
        check_eq("pwm_g", int'(pwm_g), int'(e_pwm[1]));
        check_eq("pwm_b", int'(pwm_b), int'(e_pwm[2]));
        @(posedge clk);
        model_step(s, p, ps);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; pause = 0;
        #2;
        rst_n = 0;
        #1;
        check_eq("rst_duty_r", int'(duty_r), 0);
        check_eq("rst_duty_g", int'(duty_g), 0);
        check_eq("rst_duty_b", int'(duty_b), 0);
        check_eq("rst_pwm_r", int'(pwm_r), 0);
        check_eq("rst_pwm_b", int'(pwm_b), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_key_idx", int'(key_idx), 0);
        check_eq("rst_key_done", int'(key_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        m_busy = 0; m_hold = 0; m_key = 0; m_el = 0; m_cnt = 0;
        m_from = 0; m_to = 1;
        for (int ch = 0; ch < 3; ch++) e_pwm[ch] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kd_count, pwm_b_low, hi, pause_left;
        rst_n = 1; start = 0; stop = 0; pause = 0;
        do_reset();
        $display("reset: outputs cleared");

        // Ramp 0->1 with a 50-cycle pause: completion lands exactly 50 cycles late.
        cycle(1, 0, 0);
        repeat (20) cycle(0, 0, 0);
        repeat (50) cycle(0, 0, 1);
        repeat (380) cycle(0, 0, 0);
        check_eq("pause_duty_r_before", obs_duty_r, 99);
        check_eq("pause_key_before", obs_key_idx, 0);
        cycle(0, 0, 0);
        check_eq("pause_duty_r_after", obs_duty_r, 100);
        check_eq("pause_key_after", obs_key_idx, 1);
        $display("ramp 0->1 with pause: done");

        // Mixed ramp, wrap-around and restart, with ignored start pulses.
        kd_count = 0; pwm_b_low = 0;
        for (int i = 0; i < 1200; i++) begin
            cycle(($urandom % 25) == 0, 0, 0);
            kd_count  += obs_key_done;
            pwm_b_low += (obs_pwm_b == 0) ? 1 : 0;
        end
        check_eq("key_done_count", kd_count, 4);
        check_eq("pwm_b_low_count", pwm_b_low, 0);
        check_eq("still_busy", obs_busy, 1);
        $display("mixed ramp and wrap-around: done");

        // Stop in the last HOLD cycle must suppress key_done.
        n = 0;
        while (!(m_busy && m_hold && m_el == HOLD - 1) && n < 1000) begin
            cycle(0, 0, 0);
            n++;
        end
        check_eq("hold_reached", int'(n < 1000), 1);
        cycle(0, 1, 0);
        check_eq("stop_key_done", obs_key_done, 0);
        cycle(0, 0, 0);
        check_eq("stop_busy", obs_busy, 0);
        check_eq("stop_duty_r", obs_duty_r, 0);
        check_eq("stop_pwm_b_t1", obs_pwm_b, 1);
        cycle(0, 0, 0);
        check_eq("stop_pwm_b_t2", obs_pwm_b, 0);
        $display("stop mid-hold: done");

        cycle(1, 1, 0);
        cycle(0, 0, 0);
        check_eq("start_stop_idle", obs_busy, 0);
        $display("start+stop from idle: done");

        // Randomized control traffic.
        pause_left = 0;
        for (int i = 0; i < 4000; i++) begin
            bit ps;
            ps = 0;
            if (pause_left > 0) begin
                ps = 1;
                pause_left--;
            end else if (($urandom % 300) == 0) begin
                pause_left = $urandom_range(1, 60);
            end
            cycle(($urandom % 40) == 0, ($urandom % 600) == 0, ps);
        end
        $display("random traffic: done");

        // Hold duty_r at 25 via pause and count PWM high cycles.
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        n = 0;
        while (obs_duty_r != 25 && n < 300) begin
            cycle(0, 0, 0);
            n++;
        end
        check_eq("duty25_reached", int'(n < 300), 1);
        repeat (3) cycle(0, 0, 1);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1);
            hi += obs_pwm_r;
        end
        check_eq("pwm_r_high_of_100", hi, 25);
        $display("pwm duty 25: done");

        // Asynchronous reset mid-ramp, then stay idle without a new start.
        repeat (50) cycle(0, 0, 0);
        do_reset();
        repeat (20) cycle(0, 0, 0);
        check_eq("idle_after_reset", obs_busy, 0);
        $display("async reset mid-ramp: done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
